// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
// Shared definitions for the FIFO-to-stream reader: the controller state
// encoding, the default widths used by the top, and the skid-buffer depth.
// No ports; imported by rd_skid_buf and fifo_stream_reader.
package fifo_rd_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    // Three entries cover the two-cycle read pipeline plus one word of slack,
    // which is what lets the stream run at one word per cycle.
    localparam int BUF_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf
// Three-entry in-order buffer that holds words returned by the FIFO until the
// downstream stream accepts them.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   push, push_data   write one word (ignored only if full and not popping)
//   pop               remove the head word (ignored when empty)
//   head              current head word, zero while the buffer is empty
//   count             number of stored words (0..3)
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem [0:BUF_DEPTH-1];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == 2'(BUF_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

    // A push into a full buffer is still safe when the head leaves on the same edge.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'(BUF_DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Stale entries are masked so the stream data reads zero while nothing is valid.
    assign head = (count == 2'd0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Reads words from a synchronous FIFO (one-cycle read latency) and presents
// them as a valid/ready stream framed into BURST_LEN-word bursts.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   en              level enable; high permits FIFO reads
//   fifo_empty      FIFO empty flag
//   fifo_rd_en      FIFO read strobe (combinational)
//   fifo_data_out   FIFO read data, valid the cycle after fifo_rd_en
//   m_data/m_valid  stream data and valid
//   m_ready         downstream accept
//   m_last          marks the final word of each burst
//   busy            high whenever the controller is not idle
//   word_cnt        number of completed stream transfers (wraps)
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t            state;
    logic              in_flight;
    logic [1:0]        buf_count;
    logic [2:0]        pending;
    logic [BEAT_W-1:0] beat;
    logic              xfer;

    // Credits: a read is only issued if the word it returns is guaranteed a slot,
    // counting both stored words and the one still travelling from the FIFO.
    assign pending    = {1'b0, buf_count} + {2'b00, in_flight};
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (pending < 3'(BUF_DEPTH));

    assign m_valid = (buf_count != 2'd0);
    assign xfer    = m_valid && m_ready;
    assign m_last  = m_valid && (beat == LAST_BEAT);

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight),
        .push_data (fifo_data_out),
        .pop       (xfer),
        .head      (m_data),
        .count     (buf_count)
    );

    // STOP always drains fully before returning to IDLE, even if en comes back,
    // so a restart never overlaps with words still owed from the last run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if ((buf_count == 2'd0) && !in_flight) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The read strobe delayed by one cycle marks the edge on which FIFO data is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= 1'b0;
        end else begin
            in_flight <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat     <= '0;
            word_cnt <= '0;
        end else if (xfer) begin
            beat     <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
            word_cnt <= word_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Self-checking bench: a queue-based synchronous FIFO feeds the reader, and a
// queue of expected words plus burst/transfer counters predict the stream.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data_out;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic [CW-1:0] word_cnt;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .word_cnt      (word_cnt)
    );

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int            exp_beat = 0;
    int            exp_cnt = 0;
    int            xfer_cnt = 0;
    int            rd_cnt = 0;
    int            cyc_n = 0;
    int            first_rd = -1;
    int            first_valid = -1;
    int            first_xfer = -1;
    int            last_xfer = -1;
    int            xfer_since_rst = 0;
    int            first_last_idx = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic en_v, input logic ready_v);
        en      = en_v;
        m_ready = ready_v;
    endtask

    task automatic preload(input logic [DW-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_model();
        exp_beat       = 0;
        exp_cnt        = 0;
        xfer_since_rst = 0;
        first_last_idx = 0;
        first_rd       = -1;
        first_valid    = -1;
        first_xfer     = -1;
        last_xfer      = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        src_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        clear_model();
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_xfers(input string tag, input int target, input int limit);
        int n = 0;
        while ((xfer_cnt < target) && (n < limit)) begin
            tick(1);
            n++;
        end
        check_output(tag, 32'(xfer_cnt >= target), 32'd1);
    endtask

    // Synchronous FIFO model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rd_en && (src_q.size() != 0)) begin
            fifo_data_out <= src_q.pop_front();
            if (src_q.size() == 0) fifo_empty <= 1'b1;
        end
    end

    // Stream monitor: compares each transfer with the expected word queue and
    // the burst/count rules, and checks hold-stability while stalled.
    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            check_output("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
            if (fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc_n;
            end
            if (m_valid && (first_valid < 0)) first_valid = cyc_n;
            if (stalled) begin
                check_output("stall_data", 32'(m_data), 32'(held_data));
                check_output("stall_last", 32'(m_last), 32'(held_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    check_output("data", 32'(m_data), 32'(exp_q[0]));
                    check_output("last", 32'(m_last), 32'(exp_beat == BL - 1));
                    check_output("word_cnt", 32'(word_cnt), 32'(exp_cnt));
                    void'(exp_q.pop_front());
                end
                exp_beat = (exp_beat + 1) % BL;
                exp_cnt  = (exp_cnt + 1) % (1 << CW);
                xfer_cnt++;
                xfer_since_rst++;
                if (first_xfer < 0) first_xfer = cyc_n;
                last_xfer = cyc_n;
                if (m_last && (first_last_idx == 0)) first_last_idx = xfer_since_rst;
            end
            stalled   = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
        end
    end

    initial begin
        int base_rd;
        int base_x;
        int n;

        rst           = 1'b1;
        en            = 1'b0;
        m_ready       = 1'b0;
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        tick(2);
        check_output("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check_output("rst_valid", 32'(m_valid), 32'd0);
        check_output("rst_data", 32'(m_data), 32'd0);
        check_output("rst_last", 32'(m_last), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_cnt", 32'(word_cnt), 32'd0);

        // Full-rate stream of 0x10..0x17
        do_reset();
        for (int i = 0; i < 8; i++) preload(DW'(8'h10 + i));
        base_x = xfer_cnt;
        apply_stimulus(1'b1, 1'b1);
        wait_xfers("burst_timeout", base_x + 8, 40);
        tick(2);
        check_output("latency", 32'(first_valid - first_rd), 32'd2);
        check_output("throughput", 32'(last_xfer - first_xfer), 32'd7);
        check_output("cnt_after_8", 32'(word_cnt), 32'd8);
        check_output("all_delivered", 32'(exp_q.size()), 32'd0);
        check_output("idle_valid", 32'(m_valid), 32'd0);

        // Backpressure from the start: exactly three reads, head held
        do_reset();
        for (int i = 0; i < 8; i++) preload(DW'(8'h10 + i));
        base_rd = rd_cnt;
        base_x  = xfer_cnt;
        apply_stimulus(1'b1, 1'b0);
        tick(12);
        check_output("stall_reads", 32'(rd_cnt - base_rd), 32'd3);
        check_output("stall_head", 32'(m_data), 32'h10);
        check_output("stall_valid", 32'(m_valid), 32'd1);
        apply_stimulus(1'b1, 1'b1);
        wait_xfers("release_timeout", base_x + 8, 40);
        tick(2);
        check_output("release_reads", 32'(rd_cnt - base_rd), 32'd8);
        check_output("release_left", 32'(exp_q.size()), 32'd0);

        // Empty FIFO while enabled
        do_reset();
        base_rd = rd_cnt;
        apply_stimulus(1'b1, 1'b1);
        tick(20);
        check_output("empty_reads", 32'(rd_cnt - base_rd), 32'd0);
        check_output("empty_valid", 32'(m_valid), 32'd0);
        check_output("empty_busy", 32'(busy), 32'd1);

        // Disable with three words buffered: drain then idle
        do_reset();
        for (int i = 0; i < 8; i++) preload(DW'($urandom_range(0, 255)));
        apply_stimulus(1'b1, 1'b0);
        tick(10);
        base_rd = rd_cnt;
        base_x  = xfer_cnt;
        apply_stimulus(1'b0, 1'b0);
        tick(1);
        apply_stimulus(1'b0, 1'b1);
        n = 0;
        while (busy && (n < 20)) begin
            tick(1);
            n++;
        end
        check_output("stop_idle", 32'(busy), 32'd0);
        check_output("stop_reads", 32'(rd_cnt - base_rd), 32'd0);
        check_output("stop_drained", 32'(xfer_cnt - base_x), 32'd3);
        check_output("stop_fifo_left", 32'(src_q.size()), 32'd5);
        check_output("stop_valid", 32'(m_valid), 32'd0);

        // Reset mid-burst, then restart with fresh framing
        do_reset();
        for (int i = 0; i < 12; i++) preload(DW'(8'h20 + i));
        base_x = xfer_cnt;
        apply_stimulus(1'b1, 1'b1);
        wait_xfers("pre_rst_timeout", base_x + 2, 20);
        check_output("pre_rst_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_output("mid_rst_valid", 32'(m_valid), 32'd0);
        check_output("mid_rst_data", 32'(m_data), 32'd0);
        check_output("mid_rst_last", 32'(m_last), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_cnt", 32'(word_cnt), 32'd0);
        check_output("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        exp_q = src_q;
        clear_model();
        tick(2);
        rst = 1'b0;
        n = 0;
        while ((exp_q.size() != 0) && (n < 60)) begin
            tick(1);
            n++;
        end
        check_output("restart_drained", 32'(exp_q.size()), 32'd0);
        check_output("restart_first_last", 32'(first_last_idx), 32'd4);

        // Counter wrap with a 4-bit count: 17 transfers leave 1
        do_reset();
        for (int i = 0; i < 17; i++) preload(DW'($urandom_range(0, 255)));
        base_x = xfer_cnt;
        apply_stimulus(1'b1, 1'b1);
        wait_xfers("wrap_timeout", base_x + 17, 60);
        tick(1);
        check_output("wrap_cnt", 32'(word_cnt), 32'd1);

        // Random backpressure and enable toggling
        do_reset();
        for (int i = 0; i < 24; i++) preload(DW'($urandom_range(0, 255)));
        for (int i = 0; i < 120; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) en = ~en;
            tick(1);
        end
        apply_stimulus(1'b1, 1'b1);
        n = 0;
        while ((exp_q.size() != 0) && (n < 200)) begin
            tick(1);
            n++;
        end
        check_output("random_drained", 32'(exp_q.size()), 32'd0);
        tick(2);
        check_output("random_valid", 32'(m_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the FIFO word and the stream data.
REQ-002 Parameter BURST_LEN, default 4, number of words per burst framed by m_last.
REQ-003 Parameter CNT_WIDTH, default 16, width of the delivered-word counter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock shared with the synchronous FIFO.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 en  in  1  level enable; high permits FIFO reads.
REQ-008 fifo_empty  in  1  FIFO empty flag.
REQ-009 fifo_rd_en  out  1  FIFO read strobe, one word per asserted cycle.
REQ-010 fifo_data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-011 m_data  out  DATA_WIDTH  stream data.
REQ-012 m_valid  out  1  stream data valid.
REQ-013 m_ready  in  1  downstream accept; transfer when m_valid and m_ready both high.
REQ-014 m_last  out  1  high with the final word of each BURST_LEN-word burst.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 word_cnt  out  CNT_WIDTH  count of completed stream transfers.

Function
REQ-017 States SHALL be IDLE, RUN, STOP; IDLE->RUN when en=1; RUN->STOP when en=0; STOP->IDLE when buffer and in-flight read are both empty.
REQ-018 en reasserted during STOP SHALL NOT abort draining; the block returns to RUN via IDLE on the first en=1 cycle after draining.
REQ-019 fifo_rd_en SHALL be combinational: state==RUN and fifo_empty==0 and (occupancy + in-flight) < 3.
REQ-020 fifo_data_out SHALL be captured into a 3-entry in-order buffer on the edge ending the cycle after each fifo_rd_en.
REQ-021 m_valid SHALL equal buffer non-empty; m_data SHALL be the buffer head.
REQ-022 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-023 First m_valid SHALL assert exactly 2 cycles after the first fifo_rd_en; sustained throughput SHALL be one word per cycle with m_ready held high.
REQ-024 Simultaneous capture and transfer SHALL keep occupancy unchanged; no word is lost, duplicated or reordered.
REQ-025 A beat counter (0..BURST_LEN-1) SHALL advance per transfer and wrap; m_last=1 when the head word is at beat BURST_LEN-1.
REQ-026 word_cnt SHALL increment by 1 per transfer and wrap modulo 2^CNT_WIDTH.
REQ-027 fifo_rd_en SHALL never assert while fifo_empty=1 or in IDLE/STOP.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, word_cnt=0, beat counter 0, buffer and in-flight flag cleared.
REQ-029 Reset mid-operation SHALL discard buffered and in-flight words; no partial burst framing survives.

Structure
REQ-030 Package fifo_rd_pkg SHALL hold the state enum typedef and default DATA_WIDTH/BURST_LEN/CNT_WIDTH constants.
REQ-031 The buffer SHALL be a sub-module rd_skid_buf (3-entry, push/pop, count output); FSM, credit logic and counters stay in the top.

Verification
REQ-032 FIFO holds 0x10..0x17, en=1, m_ready=1 -> words 0x10..0x17 in order, one per cycle, m_last on 0x13 and 0x17, word_cnt=8.
REQ-033 Same preload, m_ready=0 -> fifo_rd_en asserts exactly 3 times, m_data holds 0x10; m_ready=1 -> remaining words delivered without loss or duplication.
REQ-034 fifo_empty=1, en=1 for 20 cycles -> fifo_rd_en never asserts, m_valid=0, busy=1.
REQ-035 en dropped with 3 words buffered, m_ready=1 -> no further fifo_rd_en, 3 words delivered, then IDLE, busy=0.
REQ-036 rst pulsed while m_valid=1 mid-burst -> all outputs 0 at once; after restart m_last on the 4th delivered word.
REQ-037 CNT_WIDTH=4, 17 transfers -> word_cnt=1.
